// File: rtl/dspl_sched_pkg.sv
// Shared types and constants for the display scheduler: view states, edit-field
// codes, digit-vector constants and the combinational digit packer.
package dspl_sched_pkg;

  typedef enum logic {
    TIME  = 1'b0,
    ALARM = 1'b1
  } view_t;

  typedef enum logic [1:0] {
    EDIT_NONE    = 2'd0,
    EDIT_HOURS   = 2'd1,
    EDIT_MINUTES = 2'd2,
    EDIT_SECONDS = 2'd3
  } edit_t;

  localparam logic [5:0] DIG_OFF     = 6'b000001;
  localparam logic [3:0] ALARM_GLYPH = 4'hA;

  // Digit vector: [5] enable, [4:1] value, [0] decimal point (active-low).
  function automatic logic [5:0] dig(input logic en, input logic [3:0] val, input logic dp);
    return en ? {1'b1, val, ~dp} : DIG_OFF;
  endfunction

  // Returns {d1..d8}, d1 in the top six bits.
  function automatic logic [47:0] pack_digits(
    input view_t       v,
    input logic [23:0] t,
    input logic [15:0] a,
    input logic [1:0]  edit,
    input logic        blink_on
  );
    logic vis_h;
    logic vis_m;
    logic vis_s;
    vis_h = !((edit == EDIT_HOURS)   && !blink_on);
    vis_m = !((edit == EDIT_MINUTES) && !blink_on);
    vis_s = !((edit == EDIT_SECONDS) && !blink_on);
    if (v == ALARM) begin
      return {dig(1'b1, ALARM_GLYPH, 1'b0), DIG_OFF, DIG_OFF,
              dig(a[15:12] != 4'd0, a[15:12], 1'b0), dig(1'b1, a[11:8], 1'b1),
              dig(1'b1, a[7:4], 1'b0), dig(1'b1, a[3:0], 1'b0), DIG_OFF};
    end
    return {dig(vis_h && (t[23:20] != 4'd0), t[23:20], 1'b0), dig(vis_h, t[19:16], 1'b1),
            DIG_OFF,
            dig(vis_m, t[15:12], 1'b0), dig(vis_m, t[11:8], 1'b1),
            DIG_OFF,
            dig(vis_s, t[7:4], 1'b0), dig(vis_s, t[3:0], 1'b0)};
  endfunction

endpackage

// File: rtl/dspl_sched_blink_gen.sv
// Blink phase generator: half-period counter with a toggle on wrap, restarted
// visible whenever the edited field changes.
module dspl_blink_gen #(
  parameter int unsigned HALF_BLINK_COUNT = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_edit_field,
  output logic       o_blink_nxt
);

  localparam int unsigned CW = (HALF_BLINK_COUNT > 1) ? $clog2(HALF_BLINK_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_BLINK_COUNT - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_blink_on;
  logic [1:0]    r_prev_edit;
  logic          w_restart;
  logic          w_wrap;

  // Next-state value is exported so the registered digits line up with the
  // blink phase of the same edge.
  always_comb begin
    w_restart   = (i_edit_field != r_prev_edit);
    w_wrap      = (r_cnt == LAST);
    w_cnt_nxt   = r_cnt + 1'b1;
    o_blink_nxt = r_blink_on;
    if (w_restart) begin
      w_cnt_nxt   = '0;
      o_blink_nxt = 1'b1;
    end else if (w_wrap) begin
      w_cnt_nxt   = '0;
      o_blink_nxt = ~r_blink_on;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_blink_on  <= 1'b1;
      r_prev_edit <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_blink_on  <= o_blink_nxt;
      r_prev_edit <= i_edit_field;
    end
  end

endmodule

// File: rtl/dspl_sched.sv
// Display scheduler: chooses between the time and alarm views, runs the alarm
// hold timer and registers the packed eight-digit display vector.
module dspl_sched
  import dspl_sched_pkg::*;
#(
  parameter int unsigned HALF_BLINK_COUNT = 25000000,
  parameter int unsigned HOLD_SECS        = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic [23:0] time_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic        alarm_req,
  input  logic [1:0]  edit_field,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8,
  output logic        view
);

  localparam int unsigned HW = $clog2(HOLD_SECS + 1);
  localparam logic [HW-1:0] HOLD_VAL = HW'(HOLD_SECS);

  view_t         r_state;
  view_t         w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic          w_blink_nxt;
  logic [47:0]   w_digits;
  logic [47:0]   r_digits;

  dspl_blink_gen #(
    .HALF_BLINK_COUNT(HALF_BLINK_COUNT)
  ) u_blink (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_edit_field (edit_field),
    .o_blink_nxt  (w_blink_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (edit_field != EDIT_NONE) begin
      w_state_nxt = TIME;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        TIME: begin
          if (alarm_req) begin
            w_state_nxt = ALARM;
            w_hold_nxt  = HOLD_VAL;
          end
        end
        ALARM: begin
          // A reload request takes priority over a coincident second tick.
          if (alarm_req) begin
            w_hold_nxt = HOLD_VAL;
          end else if (sec_tick) begin
            if (r_hold == HW'(1)) begin
              w_state_nxt = TIME;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold - 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = TIME;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  // Packing from the next state keeps the digits and the view flag in step.
  always_comb begin
    w_digits = pack_digits(w_state_nxt, time_bcd, alarm_bcd, edit_field, w_blink_nxt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= TIME;
      r_hold   <= '0;
      r_digits <= {8{DIG_OFF}};
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_digits <= w_digits;
    end
  end

  assign view = (r_state == ALARM);
  assign d1   = r_digits[47:42];
  assign d2   = r_digits[41:36];
  assign d3   = r_digits[35:30];
  assign d4   = r_digits[29:24];
  assign d5   = r_digits[23:18];
  assign d6   = r_digits[17:12];
  assign d7   = r_digits[11:6];
  assign d8   = r_digits[5:0];

endmodule

// File: tb/tb_dspl_sched.sv
// Scoreboard bench for dspl_sched: stimulus pushes reference-model predictions,
// a negedge monitor pops and compares the registered display outputs.
module tb_dspl_sched;

  localparam int unsigned HBC  = 4;
  localparam int          HOLD = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sec_tick = 1'b0;
  logic [23:0] time_bcd = '0;
  logic [15:0] alarm_bcd = '0;
  logic        alarm_req = 1'b0;
  logic [1:0]  edit_field = '0;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic        view;

  dspl_sched #(
    .HALF_BLINK_COUNT(HBC),
    .HOLD_SECS(HOLD)
  ) dut (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .time_bcd(time_bcd),
    .alarm_bcd(alarm_bcd), .alarm_req(alarm_req), .edit_field(edit_field),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .view(view)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] d;
    logic        v;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;

  // Reference model state: view mode, seconds left in the hold, cycles since
  // the blink phase last restarted, and the last edit-field value seen.
  bit          m_alarm;
  int          m_hold;
  int          m_since;
  logic [1:0]  m_prev;

  function automatic logic [47:0] expect_digits(bit alarm, logic [23:0] t, logic [15:0] a,
                                                logic [1:0] ef, bit blink);
    bit          en[8];
    logic [3:0]  val[8];
    bit          dp[8];
    int          pos[6];
    logic [47:0] r;
    pos = '{0, 1, 3, 4, 6, 7};
    for (int i = 0; i < 8; i++) begin
      en[i] = 0; val[i] = '0; dp[i] = 0;
    end
    if (alarm) begin
      en[0] = 1; val[0] = 4'hA;
      val[3] = a[15:12]; val[4] = a[11:8]; val[5] = a[7:4]; val[6] = a[3:0];
      en[3] = (a[15:12] != 4'd0); en[4] = 1; en[5] = 1; en[6] = 1;
      dp[4] = 1;
    end else begin
      for (int k = 0; k < 6; k++) begin
        val[pos[k]] = t[23-4*k -: 4];
        en[pos[k]]  = 1;
      end
      en[0] = (t[23:20] != 4'd0);
      dp[1] = 1; dp[4] = 1;
      if (ef != 2'd0 && !blink) begin
        en[3*(int'(ef)-1)]   = 0;
        en[3*(int'(ef)-1)+1] = 0;
      end
    end
    for (int i = 0; i < 8; i++)
      r[47-6*i -: 6] = en[i] ? {1'b1, val[i], ~dp[i]} : 6'b000001;
    return r;
  endfunction

  function automatic logic [23:0] rand_time();
    int h, m, s;
    h = int'($urandom_range(0, 23));
    m = int'($urandom_range(0, 59));
    s = int'($urandom_range(0, 59));
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] rand_alarm();
    int h, m;
    h = int'($urandom_range(0, 23));
    m = int'($urandom_range(0, 59));
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic model_reset();
    m_alarm = 0; m_hold = 0; m_since = 0; m_prev = 2'd0;
  endtask

  // Drives one clock's worth of inputs, predicts the result of the coming
  // edge, then waits until just after the following falling edge.
  task automatic cycle(input logic tick, input logic req, input logic [1:0] ef,
                       input logic [23:0] t, input logic [15:0] a);
    exp_t e;
    bit   blink;
    sec_tick = tick; alarm_req = req; edit_field = ef; time_bcd = t; alarm_bcd = a;
    if (ef != m_prev) m_since = 0;
    else m_since++;
    m_prev = ef;
    blink = ((m_since / int'(HBC)) % 2) == 0;
    if (ef != 2'd0) begin
      m_alarm = 0; m_hold = 0;
    end else if (!m_alarm) begin
      if (req) begin m_alarm = 1; m_hold = HOLD; end
    end else if (req) begin
      m_hold = HOLD;
    end else if (tick) begin
      m_hold--;
      if (m_hold == 0) m_alarm = 0;
    end
    e.d = expect_digits(m_alarm, t, a, ef, blink);
    e.v = m_alarm;
    q.push_back(e);
    @(negedge clock); #1;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (q.size() != 0) begin
      e_mon = q.pop_front();
      n_cmp++;
      if ({d1, d2, d3, d4, d5, d6, d7, d8} !== e_mon.d) begin
        n_bad++;
        $display("FAIL digits cyc%0d got %h exp %h", cyc, {d1, d2, d3, d4, d5, d6, d7, d8}, e_mon.d);
      end
      n_cmp++;
      if (view !== e_mon.v) begin
        n_bad++;
        $display("FAIL view cyc%0d got %0b exp %0b", cyc, view, e_mon.v);
      end
    end
  end

  task automatic check_reset(input string tag);
    n_cmp++;
    if ({d1, d2, d3, d4, d5, d6, d7, d8} !== {8{6'b000001}}) begin
      n_bad++;
      $display("FAIL %s_digits got %h exp %h", tag, {d1, d2, d3, d4, d5, d6, d7, d8}, {8{6'b000001}});
    end
    n_cmp++;
    if (view !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_view got %0b exp 0", tag, view);
    end
  endtask

  logic [23:0] rt;
  logic [15:0] ra;
  logic [1:0]  ref_ef;

  initial begin
    model_reset();
    #12;
    check_reset("por");
    @(negedge clock); #1;
    reset = 1'b1;

    // Time view with leading-zero hour
    repeat (3) cycle(0, 0, 2'd0, 24'h093045, 16'h1230);
    // Alarm view and full hold
    cycle(0, 1, 2'd0, 24'h093045, 16'h1230);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 2'd0, 24'h093046, 16'h1230);
      cycle(0, 0, 2'd0, 24'h093046, 16'h1230);
    end
    cycle(0, 0, 2'd0, 24'h093046, 16'h0905);
    // Reload coinciding with a tick
    cycle(0, 1, 2'd0, 24'h235959, 16'h0905);
    repeat (3) cycle(1, 0, 2'd0, 24'h235959, 16'h0905);
    cycle(1, 1, 2'd0, 24'h235959, 16'h0905);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 2'd0, 24'h235959, 16'h0905);
      cycle(1, 0, 2'd0, 24'h235959, 16'h0905);
    end
    cycle(0, 0, 2'd0, 24'h235959, 16'h0905);
    // Minute blinking, then hours and seconds
    repeat (20) cycle(0, 0, 2'd2, 24'h120734, 16'h0905);
    repeat (10) cycle(0, 0, 2'd1, 24'h120734, 16'h0905);
    repeat (10) cycle(1, 0, 2'd3, 24'h120734, 16'h0905);
    cycle(0, 0, 2'd0, 24'h120734, 16'h0905);
    // Editing while in alarm view cancels it and masks the request
    cycle(0, 1, 2'd0, 24'h120734, 16'h1545);
    cycle(0, 0, 2'd1, 24'h120734, 16'h1545);
    cycle(0, 1, 2'd1, 24'h120734, 16'h1545);
    repeat (3) cycle(0, 0, 2'd0, 24'h120734, 16'h1545);
    // Reset mid-hold
    cycle(0, 1, 2'd0, 24'h120734, 16'h1545);
    repeat (2) cycle(1, 0, 2'd0, 24'h120734, 16'h1545);
    reset = 1'b0;
    #1;
    check_reset("mid_async");
    @(posedge clock); #1;
    check_reset("mid_held");
    @(negedge clock); #1;
    reset = 1'b1;
    model_reset();
    repeat (3) cycle(1, 0, 2'd0, 24'h120734, 16'h1545);

    // Randomized traffic
    rt = rand_time();
    ra = rand_alarm();
    ref_ef = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ref_ef = (ref_ef != 2'd0) ? 2'd0 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) rt = rand_time();
      if ($urandom_range(0, 31) == 0) ra = rand_alarm();
      cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) == 0),
            ($urandom_range(0, 199) == 0) ? 2'($urandom_range(0, 3)) : ref_ef, rt, ra);
    end

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
